// File: rtl/sdm2_dac.sv
// sdm2_dac: second-order sigma-delta 1-bit DAC with a click-free soft-mute ramp.
// Takes one unsigned sample per clock, applies a 0..GMAX gain that ramps one
// step every RAMP_DIV clocks when mute changes, and drives a 1-bit stream.
// Optional feature: define SDM2_DAC_DITHER_EN to add 2-bit LFSR dither into
// the first integrator, which breaks up idle tones.
module sdm2_dac #(
    parameter int MSBI     = 7,
    parameter int RAMP_DIV = 256,
    parameter int GW       = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mute,
    input  logic [MSBI:0] d,
    output logic          q,
    output logic          muted
);

    localparam int N  = MSBI + 1;     // sample width
    localparam int W1 = N + 2;        // first integrator width
    localparam int W2 = N + 4;        // second integrator width
    localparam int S1 = W1 + 2;       // headroom for the unsaturated i1 sum
    localparam int S2 = W2 + 2;       // headroom for the unsaturated i2 sum
    localparam int P  = N + GW + 1;   // signed product width
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [N-1:0]         MID      = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N:0]    FB_POS   = {2'b01, {(N-1){1'b0}}};
    localparam logic signed [N:0]    FB_NEG   = {2'b11, {(N-1){1'b0}}};
    localparam logic signed [W1-1:0] I1_MAX   = {1'b0, {(W1-1){1'b1}}};
    localparam logic signed [W1-1:0] I1_MIN   = {1'b1, {(W1-1){1'b0}}};
    localparam logic signed [W2-1:0] I2_MAX   = {1'b0, {(W2-1){1'b1}}};
    localparam logic signed [W2-1:0] I2_MIN   = {1'b1, {(W2-1){1'b0}}};
    localparam logic [GW:0]          G_FULL   = {1'b1, {GW{1'b0}}};
    localparam logic [GW:0]          G_ONE    = (GW+1)'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(RAMP_DIV - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_MUTED    = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW:0]           g_q, g_d;
    logic signed [N-1:0]   x_q, x_d;
    logic signed [W1-1:0]  i1_q, i1_d;
    logic signed [W2-1:0]  i2_q, i2_d;
    logic                  q_q, q_d;
    logic                  muted_q, muted_d;

    logic                  wrap;
    logic signed [P-1:0]   prod;
    logic signed [P-1:0]   xe_w;
    logic signed [N:0]     fb;
    logic signed [S1-1:0]  sum1;
    logic signed [S2-1:0]  sum2;

`ifdef SDM2_DAC_DITHER_EN
    logic [15:0]           lfsr_q, lfsr_d;

    // Dither source: Fibonacci LFSR, taps 16,14,13,11, advancing every clock
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
`endif

    // Ramp FSM: walks the gain between 0 and GMAX one step per counter wrap
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        wrap    = (cnt_q == CNT_LAST);
        case (state_q)
            ST_PLAY: begin
                g_d = G_FULL;
                if (mute) state_d = ST_FADE_OUT;
            end
            ST_FADE_OUT: begin
                if (!mute) begin
                    state_d = ST_FADE_IN;            // reverse from the current gain
                end else if (g_q == '0) begin
                    state_d = ST_MUTED;              // reached via an instant reversal at g=0
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
                    if (wrap) begin
                        g_d = g_q - G_ONE;
                        if (g_q == G_ONE) state_d = ST_MUTED;
                    end
                end
            end
            ST_MUTED: begin
                g_d = '0;
                if (!mute) state_d = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (mute) begin
                    state_d = ST_FADE_OUT;
                end else if (g_q == G_FULL) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
                    if (wrap) begin
                        g_d = g_q + G_ONE;
                        if (g_q == G_FULL - G_ONE) state_d = ST_PLAY;
                    end
                end
            end
            default: begin
                state_d = ST_MUTED;
                g_d     = '0;
            end
        endcase
        // The ramp counter restarts on every state entry
        if (state_d != state_q) cnt_d = '0;
        muted_d = (state_d == ST_MUTED);
    end

    // Modulator datapath: input offset, gain, two saturating integrators, quantiser
    always_comb begin
        x_d  = $signed(d ^ MID);                    // d - 2^(N-1)
        prod = P'(x_q) * P'($signed({1'b0, g_q}));
        xe_w = prod >>> GW;                         // floor division by GMAX
        fb   = q_q ? FB_POS : FB_NEG;

        sum1 = S1'(i1_q) + S1'(xe_w) - S1'(fb);
`ifdef SDM2_DAC_DITHER_EN
        sum1 = sum1 + S1'($signed(lfsr_q[1:0]));
`endif
        if (sum1 > S1'(I1_MAX))      i1_d = I1_MAX;
        else if (sum1 < S1'(I1_MIN)) i1_d = I1_MIN;
        else                         i1_d = $signed(sum1[W1-1:0]);

        // Second integrator consumes the old i1, not i1_d
        sum2 = S2'(i2_q) + S2'(i1_q) - S2'(fb);
        if (sum2 > S2'(I2_MAX))      i2_d = I2_MAX;
        else if (sum2 < S2'(I2_MIN)) i2_d = I2_MIN;
        else                         i2_d = $signed(sum2[W2-1:0]);

        q_d = ~i2_d[W2-1];                          // i2_next >= 0
    end

    // State register: everything returns to the silent MUTED state on reset
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= ST_MUTED;
            cnt_q   <= '0;
            g_q     <= '0;
            x_q     <= '0;
            i1_q    <= '0;
            i2_q    <= '0;
            q_q     <= 1'b0;
            muted_q <= 1'b1;
`ifdef SDM2_DAC_DITHER_EN
            lfsr_q  <= 16'hACE1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            x_q     <= x_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            q_q     <= q_d;
            muted_q <= muted_d;
`ifdef SDM2_DAC_DITHER_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign q     = q_q;
    assign muted = muted_q;

endmodule
